// File: rtl/vram_arbiter.sv
// Shares the video SRAM between the text-mode fetch pipeline and buffered CPU writes.
// CPU writes are synchronised, queued, and replayed in the free fetch slot or during blanking.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 15,
  parameter int DW         = 8,
  parameter int BLANK_FAST = 1
) (
  input  logic          CLK_50,
  input  logic          nRST,
  input  logic          PIX_EN,
  input  logic [2:0]    X_PHASE,
  input  logic          BLANK,
  input  logic [AW-1:0] VID_A,
  input  logic [AW-1:0] CPU_A,
  input  logic [DW-1:0] CPU_D,
  input  logic          CPU_nWR,
  output logic          CPU_WAIT,
  output logic          OVERFLOW,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_DO,
  output logic          RAM_DOE,
  output logic          RAM_nWE,
  output logic          RAM_nOE,
  output logic          WR_ACTIVE
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE1 = 3'd2,
    STROBE2 = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic sync1_q, sync2_q, sync3_q;
  logic push, pop, push_ok, full, empty, go;

  logic [AW+DW-1:0] mem [FIFO_DEPTH];
  logic [AW+DW-1:0] head_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;

  logic nwe_q, nwe_d, noe_q, noe_d, doe_q, doe_d;
  logic wr_active_q, wr_active_d, wait_q, wait_d, overflow_q, overflow_d;

  // sync3_q holds the previous synchronised level so a 1->0 step is one push
  always_ff @(posedge CLK_50) begin
    if (!nRST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= CPU_nWR;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign push    = sync3_q & ~sync2_q;
  assign full    = (count_q == PW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = (state_q == HOLD);
  assign push_ok = push & (~full | pop);
  assign go      = (state_q == IDLE) & ~empty & PIX_EN &
                   ((X_PHASE == 3'd5) | ((BLANK_FAST != 0) & BLANK));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    wait_d = (count_d == PW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = SETUP;
      SETUP:   state_d = STROBE1;
      STROBE1: state_d = STROBE2;
      STROBE2: state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Controls are registered off the next state so they line up with state_q
    nwe_d       = ~((state_d == STROBE1) | (state_d == STROBE2));
    noe_d       = (state_d != IDLE);
    doe_d       = (state_d != IDLE);
    wr_active_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_50) begin
    if (!nRST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      doe_q       <= 1'b0;
      wr_active_q <= 1'b0;
      wait_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      nwe_q       <= nwe_d;
      noe_q       <= noe_d;
      doe_q       <= doe_d;
      wr_active_q <= wr_active_d;
      wait_q      <= wait_d;
      overflow_q  <= overflow_d;
    end
  end

  // Head entry is read on go, so address/data are held for the whole slot
  always_ff @(posedge CLK_50) begin
    if (nRST && push_ok) mem[wr_ptr_q[IW-1:0]] <= {CPU_A, CPU_D};
    if (go)              head_q <= mem[rd_ptr_q[IW-1:0]];
  end

  assign RAM_A     = (state_q == IDLE) ? VID_A : head_q[AW+DW-1:DW];
  assign RAM_DO    = head_q[DW-1:0];
  assign RAM_DOE   = doe_q;
  assign RAM_nWE   = nwe_q;
  assign RAM_nOE   = noe_q;
  assign WR_ACTIVE = wr_active_q;
  assign CPU_WAIT  = wait_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: table of single writes plus hand sequences for
// fill/overflow, push-during-pop, blanking bursts and reset in the middle of a write.
module tb_vram_arbiter;

  logic        CLK_50 = 1'b0;
  logic        nRST, PIX_EN, BLANK, CPU_nWR;
  logic [2:0]  X_PHASE;
  logic [14:0] VID_A, CPU_A;
  logic [7:0]  CPU_D;

  logic        CPU_WAIT, OVERFLOW, RAM_DOE, RAM_nWE, RAM_nOE, WR_ACTIVE;
  logic [14:0] RAM_A;
  logic [7:0]  RAM_DO;

  logic        w0_wait, w0_ovf, w0_doe, w0_nwe, w0_noe, w0_wa;
  logic [14:0] w0_a;
  logic [7:0]  w0_do;

  always #10 CLK_50 = ~CLK_50;

  vram_arbiter #(.FIFO_DEPTH(4), .AW(15), .DW(8), .BLANK_FAST(1)) dut (
    .CLK_50(CLK_50), .nRST(nRST), .PIX_EN(PIX_EN), .X_PHASE(X_PHASE), .BLANK(BLANK),
    .VID_A(VID_A), .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_nWR(CPU_nWR),
    .CPU_WAIT(CPU_WAIT), .OVERFLOW(OVERFLOW), .RAM_A(RAM_A), .RAM_DO(RAM_DO),
    .RAM_DOE(RAM_DOE), .RAM_nWE(RAM_nWE), .RAM_nOE(RAM_nOE), .WR_ACTIVE(WR_ACTIVE)
  );

  // Same stimulus, but blanking does not open extra slots
  vram_arbiter #(.FIFO_DEPTH(4), .AW(15), .DW(8), .BLANK_FAST(0)) dut0 (
    .CLK_50(CLK_50), .nRST(nRST), .PIX_EN(PIX_EN), .X_PHASE(X_PHASE), .BLANK(BLANK),
    .VID_A(VID_A), .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_nWR(CPU_nWR),
    .CPU_WAIT(w0_wait), .OVERFLOW(w0_ovf), .RAM_A(w0_a), .RAM_DO(w0_do),
    .RAM_DOE(w0_doe), .RAM_nWE(w0_nwe), .RAM_nOE(w0_noe), .WR_ACTIVE(w0_wa)
  );

  typedef struct {
    int          start;
    logic [14:0] a;
    logic [7:0]  d;
    logic [2:0]  ph;
    logic [7:0]  pat;
    int          len;
    bit          shape_ok;
  } rec_t;

  typedef struct {
    logic        blank;
    logic [14:0] a;
    logic [7:0]  d;
    int          lat;
    logic [2:0]  ph;
  } vec_t;

  int   checks = 0;
  int   fails  = 0;
  int   cyc_n  = 0;
  int   nstarts = 0;
  bit   vid_run = 0;
  bit   wa_prev = 0;
  bit   wa0_prev = 0;
  rec_t cur;
  rec_t log_q[$];
  int   st0_q[$];
  logic [2:0] ph0_q[$];
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample outputs just after the edge, log write windows, advance video timing
  task automatic cyc();
    @(posedge CLK_50);
    #1;
    cyc_n++;
    if (WR_ACTIVE === 1'b1 && !wa_prev) begin
      cur.start = cyc_n; cur.a = RAM_A; cur.d = RAM_DO; cur.ph = X_PHASE;
      cur.pat = 8'h00; cur.len = 0; cur.shape_ok = 1'b1;
      nstarts++;
    end
    if (WR_ACTIVE === 1'b1) begin
      cur.len++;
      cur.pat = {cur.pat[6:0], RAM_nWE};
      if (RAM_A !== cur.a || RAM_DO !== cur.d || RAM_nOE !== 1'b1 || RAM_DOE !== 1'b1)
        cur.shape_ok = 1'b0;
    end
    if (WR_ACTIVE !== 1'b1 && wa_prev) log_q.push_back(cur);
    wa_prev = (WR_ACTIVE === 1'b1);
    if (w0_wa === 1'b1 && !wa0_prev) begin
      st0_q.push_back(cyc_n);
      ph0_q.push_back(X_PHASE);
    end
    wa0_prev = (w0_wa === 1'b1);
    if (vid_run) begin
      if (PIX_EN) X_PHASE = X_PHASE + 3'd1;
      PIX_EN = ~PIX_EN;
    end else begin
      PIX_EN = 1'b0;
    end
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    CPU_A = a; CPU_D = d; CPU_nWR = 1'b0;
    repeat (4) cyc();
    CPU_nWR = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic wait_recs(input int n, input int budget, input string nm);
    int k = 0;
    while (log_q.size() < n && k < budget) begin cyc(); k++; end
    checks++;
    if (log_q.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: got %0d writes expected %0d", nm, log_q.size(), n);
    end
  endtask

  task automatic wait_active(input int budget, input string nm);
    int k = 0;
    while (WR_ACTIVE !== 1'b1 && k < budget) begin cyc(); k++; end
    checks++;
    if (WR_ACTIVE !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: got WR_ACTIVE=%0b expected 1", nm, WR_ACTIVE);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) cyc();
    nRST = 1'b1;
    cyc();
  endtask

  initial begin
    int n0, m0, t0, t_r, s, k;
    rec_t r;

    vecs[0] = '{1'b0, 15'h1234, 8'h5A, 11, 3'd5};
    vecs[1] = '{1'b0, 15'h7FFF, 8'hFF, 11, 3'd5};
    vecs[2] = '{1'b0, 15'h0000, 8'h00, 11, 3'd5};
    vecs[3] = '{1'b1, 15'h0ABC, 8'hC3, 5,  3'd2};

    nRST = 1'b0; CPU_nWR = 1'b1; PIX_EN = 1'b0; X_PHASE = 3'd0; BLANK = 1'b0;
    VID_A = 15'h2222; CPU_A = '0; CPU_D = '0;

    // Reset with the CPU strobe toggling
    for (int i = 0; i < 3; i++) begin
      CPU_nWR = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    chk("rst_nwe", RAM_nWE, 1);
    chk("rst_noe", RAM_nOE, 1);
    chk("rst_doe", RAM_DOE, 0);
    chk("rst_wait", CPU_WAIT, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_wa", WR_ACTIVE, 0);
    CPU_nWR = 1'b1;
    nRST = 1'b1;
    cyc();
    chk("rel_noe", RAM_nOE, 0);
    chk("rel_ram_a", RAM_A, VID_A);
    vid_run = 1'b1;
    repeat (40) cyc();
    chk("rst_no_write", nstarts, 0);

    // Single writes: align to (PIX_EN=1, X_PHASE=0) so latency is fixed
    for (int i = 0; i < 4; i++) begin
      BLANK = vecs[i].blank;
      VID_A = 15'h2222 + 15'(i);
      k = 0;
      while (!(PIX_EN && X_PHASE == 3'd0) && k < 40) begin cyc(); k++; end
      n0 = log_q.size();
      t0 = cyc_n;
      cpu_write(vecs[i].a, vecs[i].d);
      wait_recs(n0 + 1, 60, "vec");
      if (log_q.size() > n0) begin
        r = log_q[n0];
        chk("vec_a", r.a, vecs[i].a);
        chk("vec_d", r.d, vecs[i].d);
        chk("vec_latency", r.start - t0, vecs[i].lat);
        chk("vec_phase", r.ph, vecs[i].ph);
        chk("vec_nwe_pattern", {r.pat[3:0], 8'(r.len)}, {4'b1001, 8'd4});
        chk("vec_bus_stable", r.shape_ok, 1);
        chk("vec_idle_noe", RAM_nOE, 0);
        chk("vec_idle_ram_a", RAM_A, VID_A);
        $display("vec %0d blank=%0b a=%h d=%h start=+%0d phase=%0d", i, vecs[i].blank,
                 r.a, r.d, r.start - t0, r.ph);
      end
    end
    BLANK = 1'b0;

    // Fill past depth with the video timing paused, then drain one per cell
    do_reset();
    vid_run = 1'b0; PIX_EN = 1'b0;
    n0 = log_q.size();
    for (int i = 0; i < 5; i++) begin
      cpu_write(15'h0100 + 15'(i), 8'hA0 + 8'(i));
      if (i == 2) chk("fill3_wait", CPU_WAIT, 0);
      if (i == 3) begin
        chk("fill4_wait", CPU_WAIT, 1);
        chk("fill4_ovf", OVERFLOW, 0);
      end
      if (i == 4) chk("fill5_ovf", OVERFLOW, 1);
    end
    vid_run = 1'b1; PIX_EN = 1'b1;
    wait_recs(n0 + 4, 200, "drain");
    if (log_q.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        r = log_q[n0 + i];
        chk("drain_a", r.a, 15'h0100 + 15'(i));
        chk("drain_d", r.d, 8'hA0 + 8'(i));
        chk("drain_phase", r.ph, 3'd5);
        if (i > 0) chk("drain_cell_gap", r.start - log_q[n0 + i - 1].start, 16);
        $display("drain %0d a=%h d=%h start=%0d", i, r.a, r.d, r.start);
      end
    end
    repeat (40) cyc();
    chk("drop_count", log_q.size() - n0, 4);
    chk("drain_wait", CPU_WAIT, 0);
    chk("ovf_sticky", OVERFLOW, 1);

    // Push landing on the HOLD edge while full is accepted
    do_reset();
    vid_run = 1'b0; PIX_EN = 1'b0;
    n0 = log_q.size();
    for (int i = 0; i < 4; i++) cpu_write(15'h0200 + 15'(i), 8'h20 + 8'(i));
    chk("pp_full_wait", CPU_WAIT, 1);
    vid_run = 1'b1; PIX_EN = 1'b1;
    wait_active(100, "pp_active");
    cyc();
    CPU_A = 15'h0555; CPU_D = 8'h55; CPU_nWR = 1'b0;
    repeat (4) cyc();
    chk("pp_ovf", OVERFLOW, 0);
    chk("pp_wait", CPU_WAIT, 1);
    CPU_nWR = 1'b1;
    wait_recs(n0 + 5, 200, "pp_drain");
    if (log_q.size() >= n0 + 5) begin
      chk("pp_first_a", log_q[n0].a, 15'h0200);
      chk("pp_last_a", log_q[n0 + 3].a, 15'h0203);
      chk("pp_push_a", log_q[n0 + 4].a, 15'h0555);
      chk("pp_push_d", log_q[n0 + 4].d, 8'h55);
      $display("pushpop a=%h d=%h start=%0d", log_q[n0 + 4].a, log_q[n0 + 4].d,
               log_q[n0 + 4].start);
    end
    repeat (4) cyc();
    chk("pp_empty_wait", CPU_WAIT, 0);

    // Blanking burst: fast instance uses every free PIX_EN, the other waits for phase 5
    do_reset();
    vid_run = 1'b0; PIX_EN = 1'b0; BLANK = 1'b1;
    n0 = log_q.size();
    m0 = st0_q.size();
    for (int i = 0; i < 3; i++) cpu_write(15'h0300 + 15'(i), 8'h30 + 8'(i));
    t_r = cyc_n;
    vid_run = 1'b1; PIX_EN = 1'b1;
    wait_recs(n0 + 3, 60, "blank");
    if (log_q.size() >= n0 + 3) begin
      for (int i = 0; i < 3; i++) begin
        r = log_q[n0 + i];
        // go on PIX_EN, 4-cycle slot, one idle cycle, then the next PIX_EN
        chk("blank_start", r.start - t_r, 1 + 6 * i);
        chk("blank_a", r.a, 15'h0300 + 15'(i));
        chk("blank_d", r.d, 8'h30 + 8'(i));
        $display("blank %0d a=%h d=%h start=+%0d", i, r.a, r.d, r.start - t_r);
      end
    end
    k = 0;
    while (st0_q.size() < m0 + 3 && k < 200) begin cyc(); k++; end
    chk("slow_count", st0_q.size() - m0, 3);
    if (st0_q.size() >= m0 + 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("slow_phase", ph0_q[m0 + i], 3'd5);
        if (i > 0) chk("slow_cell_gap", st0_q[m0 + i] - st0_q[m0 + i - 1], 16);
      end
    end
    BLANK = 1'b0;

    // Reset during STROBE1 kills the write and the queue
    do_reset();
    vid_run = 1'b0; PIX_EN = 1'b0;
    cpu_write(15'h0444, 8'h44);
    vid_run = 1'b1; PIX_EN = 1'b1;
    wait_active(100, "mid_active");
    cyc();
    chk("mid_strobe_nwe", RAM_nWE, 0);
    nRST = 1'b0;
    cyc();
    chk("mid_rst_nwe", RAM_nWE, 1);
    chk("mid_rst_doe", RAM_DOE, 0);
    chk("mid_rst_wa", WR_ACTIVE, 0);
    nRST = 1'b1;
    s = nstarts;
    repeat (60) cyc();
    chk("mid_no_residual", nstarts - s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
